l2_block_responder: RTL and testbench

//  Synthesizable L2-side responder for the coherence bus controller's memory port.
//  - Accepts block loads/stores from the bus controller.
//  - Models a fixed access latency and backs the data with an internal block array.
//  - Reports progress on the 2-bit l2_state handshake.
//  - Closes the loop for bus_ctrl benches and FPGA builds without a real L2.

---
 rtl/l2_block_responder.sv | 150 +++++++++++++++
 tb/tb_l2_block_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/l2_block_responder.sv
// L2-side memory-port responder: fixed-latency block load/store against an internal
// block array, with FREE/BUSY/ACCESS/ERROR progress on l2_state_o.
module l2_block_responder #(
    parameter int unsigned       BLOCK_SIZE_WORDS = 2,
    parameter int unsigned       WORD_W           = 32,
    parameter int unsigned       NUM_BLOCKS       = 64,
    parameter int unsigned       LATENCY          = 4,
    parameter logic [WORD_W-1:0] BASE_ADDR        = '0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               l2_load_i,
    input  logic                               l2_store_i,
    input  logic [WORD_W-1:0]                  l2_addr_i,
    input  logic [BLOCK_SIZE_WORDS*WORD_W-1:0] l2_store_data_i,
    output logic [BLOCK_SIZE_WORDS*WORD_W-1:0] l2_load_data_o,
    output logic [1:0]                         l2_state_o,
    output logic [15:0]                        l2_access_cnt_o
);

    localparam int unsigned BLK_W = BLOCK_SIZE_WORDS * WORD_W;
    localparam int unsigned BOFF  = $clog2(BLOCK_SIZE_WORDS * 4);
    localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Encoding doubles as the l2_state handshake value.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic               store_q, store_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLK_W-1:0]   data_q, data_d;
    logic [BLK_W-1:0]   load_data_q;
    logic [15:0]        acc_cnt_q;
    logic [BLK_W-1:0]   mem_q [NUM_BLOCKS];

    logic               req_c;
    logic               req_err_c;
    logic               below_base_c;
    logic [WORD_W-1:0]  offs_c;
    logic [WORD_W-1:0]  idx_full_c;
    logic               mem_we_c;
    logic               load_upd_c;
    logic               cnt_inc_c;

    // Address decode; the borrow out of the subtraction flags addresses below the base.
    always_comb begin
        {below_base_c, offs_c} = {1'b0, l2_addr_i} - {1'b0, BASE_ADDR};
        idx_full_c             = offs_c >> BOFF;
        req_c                  = l2_load_i | l2_store_i;
        req_err_c              = (l2_load_i & l2_store_i)
                               | below_base_c
                               | (idx_full_c >= WORD_W'(NUM_BLOCKS))
                               | (l2_addr_i[BOFF-1:0] != '0);
    end

    // Next-state and access strobes.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        store_d    = store_q;
        idx_d      = idx_q;
        data_d     = data_q;
        mem_we_c   = 1'b0;
        load_upd_c = 1'b0;
        cnt_inc_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    store_d = l2_store_i;
                    idx_d   = IDX_W'(idx_full_c);
                    data_d  = l2_store_data_i;
                    if (req_err_c) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_WAIT;
                        lat_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!req_c) begin
                    state_d = S_IDLE;
                end else if (lat_q != '0) begin
                    lat_d = lat_q - CNT_W'(1);
                end else begin
                    mem_we_c   = store_q;
                    load_upd_c = ~store_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                cnt_inc_c = 1'b1;
                state_d   = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            store_q     <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            load_data_q <= '0;
            acc_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            store_q <= store_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            if (load_upd_c) begin
                load_data_q <= mem_q[idx_q];
            end
            if (cnt_inc_c) begin
                acc_cnt_q <= acc_cnt_q + 16'd1;
            end
        end
    end

    // Backing array, cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_BLOCKS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we_c) begin
            mem_q[idx_q] <= data_q;
        end
    end

    assign l2_load_data_o  = load_data_q;
    assign l2_state_o      = 2'(state_q);
    assign l2_access_cnt_o = acc_cnt_q;

endmodule

// File: tb/tb_l2_block_responder.sv
// Self-checking bench for l2_block_responder: vector table through a scoreboard queue,
// plus hand-written abort, back-to-back and reset-during-wait sequences.
module tb_l2_block_responder;

    typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_BOTH} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [1:0]  exp_state;
        int          exp_busy;
        logic [63:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam logic [1:0] ST_FREE = 2'd0, ST_BUSY = 2'd1, ST_ACC = 2'd2, ST_ERR = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        l2_load = 1'b0;
    logic        l2_store = 1'b0;
    logic [31:0] l2_addr = '0;
    logic [63:0] l2_store_data = '0;
    logic [63:0] l2_load_data;
    logic [1:0]  l2_state;
    logic [15:0] l2_access_cnt;

    int total = 0;
    int bad   = 0;
    vec_t vecs[13];
    vec_t sb_q[$];

    l2_block_responder dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .l2_load_i       (l2_load),
        .l2_store_i      (l2_store),
        .l2_addr_i       (l2_addr),
        .l2_store_data_i (l2_store_data),
        .l2_load_data_o  (l2_load_data),
        .l2_state_o      (l2_state),
        .l2_access_cnt_o (l2_access_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input op_e op, input logic [31:0] addr, input logic [63:0] wdata);
        l2_load       = (op == OP_LOAD) || (op == OP_BOTH);
        l2_store      = (op == OP_STORE) || (op == OP_BOTH);
        l2_addr       = addr;
        l2_store_data = wdata;
    endtask

    // One full request: drive, count BUSY cycles, compare at ACCESS/ERROR and the FREE after.
    task automatic run_vec(input string tag, input vec_t v);
        vec_t e;
        int busy;
        @(negedge clk);
        drive(v.op, v.addr, v.wdata);
        sb_q.push_back(v);
        busy = 0;
        @(negedge clk);
        while (l2_state == ST_BUSY && busy < 64) begin
            busy++;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        check({tag, " state"}, 64'(l2_state), 64'(e.exp_state));
        check({tag, " busy_cycles"}, 64'(busy), 64'(e.exp_busy));
        check({tag, " load_data"}, l2_load_data, e.exp_data);
        l2_load  = 1'b0;
        l2_store = 1'b0;
        @(negedge clk);
        check({tag, " free_after"}, 64'(l2_state), 64'(ST_FREE));
        check({tag, " access_cnt"}, 64'(l2_access_cnt), 64'(e.exp_cnt));
    endtask

    function automatic vec_t mk(input op_e op, input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [1:0] st, input logic [63:0] d, input logic [15:0] c);
        vec_t v;
        v.op        = op;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_state = st;
        v.exp_busy  = (st == ST_ACC) ? 4 : 0;
        v.exp_data  = d;
        v.exp_cnt   = c;
        return v;
    endfunction

    initial begin
        logic [1:0] seq [11];
        vecs[0]  = mk(OP_LOAD,  32'h028, 64'h0,                   ST_ACC, 64'h0,                   16'd1);
        vecs[1]  = mk(OP_STORE, 32'h040, 64'hDEADBEEF_CAFEF00D,   ST_ACC, 64'h0,                   16'd2);
        vecs[2]  = mk(OP_LOAD,  32'h040, 64'h0,                   ST_ACC, 64'hDEADBEEF_CAFEF00D,   16'd3);
        vecs[3]  = mk(OP_STORE, 32'h044, 64'h1234,                ST_ERR, 64'hDEADBEEF_CAFEF00D,   16'd3);
        vecs[4]  = mk(OP_STORE, 32'h200, 64'h5678,                ST_ERR, 64'hDEADBEEF_CAFEF00D,   16'd3);
        vecs[5]  = mk(OP_BOTH,  32'h040, 64'h11112222_33334444,   ST_ERR, 64'hDEADBEEF_CAFEF00D,   16'd3);
        vecs[6]  = mk(OP_LOAD,  32'h040, 64'h0,                   ST_ACC, 64'hDEADBEEF_CAFEF00D,   16'd4);
        vecs[7]  = mk(OP_STORE, 32'h1F8, 64'hA5A5A5A5_5A5A5A5A,   ST_ACC, 64'hDEADBEEF_CAFEF00D,   16'd5);
        vecs[8]  = mk(OP_LOAD,  32'h1F8, 64'h0,                   ST_ACC, 64'hA5A5A5A5_5A5A5A5A,   16'd6);
        vecs[9]  = mk(OP_LOAD,  32'h1FC, 64'h0,                   ST_ERR, 64'hA5A5A5A5_5A5A5A5A,   16'd6);
        vecs[10] = mk(OP_STORE, 32'h000, 64'h01234567_89ABCDEF,   ST_ACC, 64'hA5A5A5A5_5A5A5A5A,   16'd7);
        vecs[11] = mk(OP_LOAD,  32'h000, 64'h0,                   ST_ACC, 64'h01234567_89ABCDEF,   16'd8);
        vecs[12] = mk(OP_LOAD,  32'h040, 64'h0,                   ST_ACC, 64'hDEADBEEF_CAFEF00D,   16'd9);
        seq = '{ST_BUSY, ST_BUSY, ST_BUSY, ST_BUSY, ST_ACC, ST_FREE,
                ST_BUSY, ST_BUSY, ST_BUSY, ST_BUSY, ST_ACC};

        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset state", 64'(l2_state), 64'(ST_FREE));
        check("reset load_data", l2_load_data, 64'h0);
        check("reset access_cnt", 64'(l2_access_cnt), 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Abort: drop the store on the second BUSY cycle.
        @(negedge clk);
        drive(OP_STORE, 32'h080, 64'hFEEDFACE_0BADF00D);
        @(negedge clk);
        check("abort busy1", 64'(l2_state), 64'(ST_BUSY));
        @(negedge clk);
        check("abort busy2", 64'(l2_state), 64'(ST_BUSY));
        l2_store = 1'b0;
        @(negedge clk);
        check("abort free", 64'(l2_state), 64'(ST_FREE));
        @(negedge clk);
        check("abort stays free", 64'(l2_state), 64'(ST_FREE));
        check("abort access_cnt", 64'(l2_access_cnt), 64'd9);
        run_vec("abort readback", mk(OP_LOAD, 32'h080, 64'h0, ST_ACC, 64'h0, 16'd10));

        // Back-to-back: load held through ACCESS is re-accepted after one FREE cycle.
        @(negedge clk);
        drive(OP_LOAD, 32'h040, 64'h0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check($sformatf("b2b state[%0d]", i), 64'(l2_state), 64'(seq[i]));
        end
        check("b2b load_data", l2_load_data, 64'hDEADBEEF_CAFEF00D);
        l2_load = 1'b0;
        @(negedge clk);
        check("b2b free", 64'(l2_state), 64'(ST_FREE));
        check("b2b access_cnt", 64'(l2_access_cnt), 64'd12);

        // Reset while a store is waiting.
        @(negedge clk);
        drive(OP_STORE, 32'h0C0, 64'h77777777_88888888);
        repeat (2) @(negedge clk);
        check("rst_mid busy", 64'(l2_state), 64'(ST_BUSY));
        rst      = 1'b1;
        l2_store = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid state", 64'(l2_state), 64'(ST_FREE));
        check("rst_mid load_data", l2_load_data, 64'h0);
        check("rst_mid access_cnt", 64'(l2_access_cnt), 64'h0);
        run_vec("rst_mid readback C0", mk(OP_LOAD, 32'h0C0, 64'h0, ST_ACC, 64'h0, 16'd1));
        run_vec("rst_mid readback 40", mk(OP_LOAD, 32'h040, 64'h0, ST_ACC, 64'h0, 16'd2));
        run_vec("rst_mid readback 28", mk(OP_LOAD, 32'h028, 64'h0, ST_ACC, 64'h0, 16'd3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
